// File: rtl/snn_cmd_sequencer.sv
// snn_cmd_sequencer: plays a stored table of {addr, cmd, arg} commands onto the
// spiking network command bus, issues CLEAR, waits a fixed evaluation window and
// captures the network's out/out_time as a result.
//
// Handshake: start is a single-cycle request, accepted only in IDLE while done
// is low; busy is high from the accepted start until the cycle done pulses.
// tbl_we is accepted only while busy is low. Every output is a register.
module snn_cmd_sequencer #(
  parameter int INT_WIDTH   = 4,
  parameter int FLOAT_WIDTH = 2*INT_WIDTH,
  parameter int CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH  = 3,
  parameter int DEPTH       = 16,
  parameter int PTR_WIDTH   = 4,
  parameter int WAIT_CYCLES = 35
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     tbl_we,
  input  logic [PTR_WIDTH-1:0]                     tbl_waddr,
  input  logic [ADDR_WIDTH+CMD_WIDTH+FLOAT_WIDTH-1:0] tbl_wdata,
  input  logic [PTR_WIDTH:0]                       num_entries,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     result,
  output logic [31:0]                              result_time,
  output logic                                     spike_seen,
  output logic [ADDR_WIDTH-1:0]                    net_addr,
  output logic [CMD_WIDTH-1:0]                     net_cmd,
  output logic [FLOAT_WIDTH-1:0]                   net_cmd_arg,
  input  logic                                     net_out,
  input  logic [31:0]                              net_out_time
);

  localparam int TW    = ADDR_WIDTH + CMD_WIDTH + FLOAT_WIDTH;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  localparam logic [CMD_WIDTH-1:0]  CMD_CLEAR = CMD_WIDTH'((1 << CMD_WIDTH) - 3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IDLE = '1;
  localparam logic [PTR_WIDTH:0]    DEPTH_L   = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GAP   = 3'd2,
    S_CLEAR = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [TW-1:0] tbl_q [DEPTH];

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  result_q, result_d;
  logic [31:0]           rtime_q, rtime_d;
  logic                  seen_q, seen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [FLOAT_WIDTH-1:0] arg_q, arg_d;
  logic [PTR_WIDTH:0]    n_q, n_d;
  logic [PTR_WIDTH:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  start_ok;
  logic [PTR_WIDTH:0]    n_clamp;
  logic [PTR_WIDTH:0]    ptr_inc;

  // A start coinciding with the done pulse is deliberately refused.
  assign start_ok = (state_q == S_IDLE) && start && !done_q;
  assign n_clamp  = (num_entries > DEPTH_L) ? DEPTH_L : num_entries;
  assign ptr_inc  = ptr_q + 1'b1;

  // Command table: plain RAM, no reset, writes locked out while a sequence runs.
  always_ff @(posedge clk) begin
    if (tbl_we && !busy_q && ({1'b0, tbl_waddr} < DEPTH_L)) begin
      tbl_q[tbl_waddr] <= tbl_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = (n_clamp != '0) ? S_ISSUE : S_CLEAR;
      S_ISSUE: state_d = S_GAP;
      S_GAP:   state_d = (ptr_inc < n_q) ? S_ISSUE : S_CLEAR;
      S_CLEAR: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; the bus idles unless ISSUE or CLEAR drives it.
  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    rtime_d  = rtime_q;
    seen_d   = seen_q;
    addr_d   = ADDR_IDLE;
    cmd_d    = '0;
    arg_d    = arg_q;
    n_d      = n_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          n_d    = n_clamp;
          ptr_d  = '0;
          busy_d = 1'b1;
        end
      end
      S_ISSUE: begin
        {addr_d, cmd_d, arg_d} = tbl_q[ptr_q[PTR_WIDTH-1:0]];
      end
      S_GAP: begin
        ptr_d = ptr_inc;
      end
      S_CLEAR: begin
        cmd_d  = CMD_CLEAR;
        seen_d = 1'b0;
        cnt_d  = CNT_LOAD;
      end
      S_WAIT: begin
        seen_d = seen_q | net_out;
        if (cnt_q == '0) begin
          result_d = net_out;
          rtime_d  = net_out_time;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Registered outputs and sequencing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
      rtime_q  <= '0;
      seen_q   <= 1'b0;
      addr_q   <= ADDR_IDLE;
      cmd_q    <= '0;
      arg_q    <= '0;
      n_q      <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rtime_q  <= rtime_d;
      seen_q   <= seen_d;
      addr_q   <= addr_d;
      cmd_q    <= cmd_d;
      arg_q    <= arg_d;
      n_q      <= n_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign result_time = rtime_q;
  assign spike_seen  = seen_q;
  assign net_addr    = addr_q;
  assign net_cmd     = cmd_q;
  assign net_cmd_arg = arg_q;

endmodule

// File: tb/tb_snn_cmd_sequencer.sv
// Testbench for snn_cmd_sequencer: directed runs with randomized table contents
// and network responses, checked cycle by cycle against a timeline model.
module tb_snn_cmd_sequencer;

  localparam int DEPTH = 16;
  localparam int WAIT  = 35;
  localparam logic [2:0] CMD_CLEAR = 3'd5;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        tbl_we;
  logic [3:0]  tbl_waddr;
  logic [13:0] tbl_wdata;
  logic [4:0]  num_entries;
  logic        start;
  logic        busy, done, result, spike_seen;
  logic [31:0] result_time;
  logic [2:0]  net_addr;
  logic [2:0]  net_cmd;
  logic [7:0]  net_cmd_arg;
  logic        net_out;
  logic [31:0] net_out_time;

  snn_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
    .num_entries(num_entries), .start(start),
    .busy(busy), .done(done), .result(result), .result_time(result_time),
    .spike_seen(spike_seen),
    .net_addr(net_addr), .net_cmd(net_cmd), .net_cmd_arg(net_cmd_arg),
    .net_out(net_out), .net_out_time(net_out_time)
  );

  // Reference state: table contents and the last argument left on the bus.
  logic [13:0] tbl_m [DEPTH];
  logic [7:0]  arg_m;
  int checks = 0;
  int errors = 0;
  bit noise  = 1'b0;

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one table write while idle
  task automatic write_entry(input int idx, input logic [13:0] data);
    tbl_we = 1'b1; tbl_waddr = idx[3:0]; tbl_wdata = data;
    @(posedge clk); #1;
    tbl_we = 1'b0;
    tbl_m[idx] = data;
  endtask

  task automatic drive_net();
    net_out      = ($urandom_range(0, 3) == 0);
    net_out_time = $urandom;
  endtask

  // One full sequence; cycle 0 is the period after the edge that accepts start.
  // rst_cyc >= 0 aborts with an asynchronous reset in that cycle.
  // last_out >= 0 forces net_out in the final window sample.
  task automatic run_seq(input int ne, input int rst_cyc, input bit stray_done, input int last_out);
    int n, total, k;
    logic [7:0]  arg_h;
    logic [2:0]  e_addr, e_cmd;
    logic [7:0]  e_arg;
    bit          seen;
    logic        res;
    logic [31:0] rtime;
    n     = (ne > DEPTH) ? DEPTH : ne;
    total = 2 + 2*n + WAIT;
    seen  = 1'b0; res = 1'b0; rtime = '0;
    num_entries = ne[4:0];
    start = 1'b1;
    drive_net();
    @(posedge clk); #1;
    start = 1'b0;
    arg_h = arg_m;
    for (int c = 0; c <= total; c++) begin
      e_addr = 3'd7; e_cmd = 3'd0;
      if (c >= 1 && c <= 2*n && (c % 2) == 1) begin
        k = (c - 1) / 2;
        e_addr = tbl_m[k][13:11];
        e_cmd  = tbl_m[k][10:8];
        arg_h  = tbl_m[k][7:0];
      end else if (c == 1 + 2*n) begin
        e_cmd = CMD_CLEAR;
      end
      e_arg = arg_h;
      chk($sformatf("busy c%0d", c), {31'b0, busy}, {31'b0, (c < total)});
      chk($sformatf("done c%0d", c), {31'b0, done}, {31'b0, (c == total)});
      chk($sformatf("addr c%0d", c), {29'b0, net_addr}, {29'b0, e_addr});
      chk($sformatf("cmd c%0d", c),  {29'b0, net_cmd},  {29'b0, e_cmd});
      chk($sformatf("arg c%0d", c),  {24'b0, net_cmd_arg}, {24'b0, e_arg});
      if (c == rst_cyc) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_addr", {29'b0, net_addr}, 32'd7);
        chk("rst_cmd",  {29'b0, net_cmd}, 32'd0);
        chk("rst_arg",  {24'b0, net_cmd_arg}, 32'd0);
        chk("rst_result", {31'b0, result}, 32'd0);
        chk("rst_rtime", result_time, 32'd0);
        chk("rst_seen", {31'b0, spike_seen}, 32'd0);
        start = 1'b0; tbl_we = 1'b0;
        @(posedge clk); #1;
        chk("rst_hold_addr", {29'b0, net_addr}, 32'd7);
        rst_n = 1'b1;
        arg_m = '0;
        @(posedge clk); #1;
        return;
      end
      if (c == total) begin
        chk("result", {31'b0, result}, {31'b0, res});
        chk("result_time", result_time, rtime);
        chk("spike_seen", {31'b0, spike_seen}, {31'b0, seen});
      end
      // Drive inputs for the next edge and record what the window will sample.
      drive_net();
      if (last_out >= 0 && c == 2*n + WAIT) net_out = last_out[0];
      if (c >= 1 + 2*n && c <= 2*n + WAIT) seen = seen | net_out;
      if (c == 2*n + WAIT) begin res = net_out; rtime = net_out_time; end
      if (c < total) begin
        start  = noise && ($urandom_range(0, 3) == 0);
        tbl_we = noise && ($urandom_range(0, 2) == 0);
        tbl_waddr = 4'($urandom_range(0, 15));
        tbl_wdata = 14'($urandom);
      end else begin
        start  = stray_done;
        tbl_we = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("post_busy", {31'b0, busy}, 32'd0);
    chk("post_done", {31'b0, done}, 32'd0);
    chk("post_result", {31'b0, result}, {31'b0, res});
    start = 1'b0;
    arg_m = arg_h;
  endtask

  // Stimulus
  initial begin
    logic [13:0] d;
    tbl_we = 1'b0; tbl_waddr = '0; tbl_wdata = '0;
    num_entries = '0; start = 1'b0; net_out = 1'b0; net_out_time = '0;
    arg_m = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_addr", {29'b0, net_addr}, 32'd7);
    chk("reset_cmd",  {29'b0, net_cmd}, 32'd0);
    chk("reset_arg",  {24'b0, net_cmd_arg}, 32'd0);
    chk("reset_result", {31'b0, result}, 32'd0);
    chk("reset_rtime", result_time, 32'd0);
    chk("reset_seen", {31'b0, spike_seen}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // XOR-style table: fixed ends, random middle, one cmd=0 slot.
    write_entry(0, {3'd1, 3'd1, 8'd7});
    for (int i = 1; i < 15; i++) begin
      d = 14'($urandom);
      if (i == 6) d[10:8] = 3'd0;
      write_entry(i, d);
    end
    write_entry(15, {3'd7, 3'd7, 8'd2});

    run_seq(16, -1, 1'b0, 1);   // in1=1,in2=0: network fires at the end
    run_seq(16, -1, 1'b0, 0);   // in1=in2=1: no output at the end
    run_seq(0,  -1, 1'b0, -1);  // empty table: CLEAR straight away
    noise = 1'b1;
    run_seq(20, -1, 1'b1, -1);  // clamp, writes/starts while busy, start on done
    noise = 1'b0;
    run_seq(16, -1, 1'b0, -1);  // readback: table unchanged by busy writes
    run_seq(5, 2*5 + 12, 1'b0, -1); // reset in the middle of the window
    run_seq(3,  -1, 1'b0, 1);   // clean run after reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_cmd_sequencer.md
Name: snn_cmd_sequencer

Overview:
Master-side driver of the spiking network command bus (addr/cmd/cmd_arg). It plays a stored table of configuration commands into a spiking network instance, then issues CLEAR. It waits a fixed evaluation window and captures the network's out/out_time as a result. It replaces hand-timed bench stimulus and sits between a host or loader and spiking_neural_network_xor.

Parameters:
INT_WIDTH, 4, integer width of network values
FLOAT_WIDTH, 2*INT_WIDTH, width of cmd_arg (signed)
CMD_WIDTH, 3, command field width; CMD_CLEAR = 2^CMD_WIDTH-3
ADDR_WIDTH, 3, neuron address width; all-ones = idle/no-target
DEPTH, 16, command table entries
PTR_WIDTH, 4, table index width (2^PTR_WIDTH >= DEPTH)
WAIT_CYCLES, 35, evaluation window length in clocks after CLEAR (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
tbl_we  in  1  table write strobe; ignored while busy
tbl_waddr  in  PTR_WIDTH  table write index
tbl_wdata  in  ADDR_WIDTH+CMD_WIDTH+FLOAT_WIDTH  {addr, cmd, arg}, addr in MSBs
num_entries  in  PTR_WIDTH+1  entries to play, sampled on accepted start; values > DEPTH clamp to DEPTH
start  in  1  start pulse; ignored while busy
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse; result valid
result  out  1  net_out sampled in the last window cycle
result_time  out  32  net_out_time sampled in the last window cycle
spike_seen  out  1  OR of net_out over the whole window
net_addr  out  ADDR_WIDTH  to network addr
net_cmd  out  CMD_WIDTH  to network cmd
net_cmd_arg  out  FLOAT_WIDTH  to network cmd_arg
net_out  in  1  from network out
net_out_time  in  32  from network out_time

Behaviour:
- All outputs registered. On reset: state IDLE; busy=0; done=0; result=0; result_time=0; spike_seen=0; net_addr=all-ones; net_cmd=0; net_cmd_arg=0. Table RAM is not reset.
- Table write: on a clk edge with tbl_we=1 and busy=0, write tbl_wdata to entry tbl_waddr. A write with tbl_waddr >= DEPTH is dropped.
- States: IDLE, ISSUE, GAP, CLEAR, WAIT, DONE.
- IDLE: when start=1, latch min(num_entries, DEPTH) as N, set ptr=0 and busy=1. Next state is ISSUE if N>0, otherwise CLEAR.
- ISSUE (1 cycle): drive entry[ptr] onto net_addr/net_cmd/net_cmd_arg, then go to GAP.
- GAP (1 cycle): net_addr=all-ones, net_cmd=0, net_cmd_arg holds its value. ptr increments. Next state is ISSUE if ptr+1<N, otherwise CLEAR.
- CLEAR (1 cycle): net_addr=all-ones, net_cmd=CMD_CLEAR. Clear spike_seen and load the window counter with WAIT_CYCLES-1.
- WAIT: net_cmd=0. Each cycle: spike_seen |= net_out. At counter==0, capture result=net_out and result_time=net_out_time, then go to DONE. Otherwise decrement the counter.
- DONE (1 cycle): done=1, busy=0 at the same edge, next state IDLE. result, result_time and spike_seen hold until the next accepted start.
- Timing from the start edge (cycle 0): entry k appears on the bus in cycle 1+2k. CLEAR appears in cycle 1+2N. The window covers cycles 2+2N .. 1+2N+WAIT_CYCLES. done is high in cycle 2+2N+WAIT_CYCLES.
- A start asserted in the same cycle as done is ignored. A start in the cycle after done is accepted.
- Commands issue strictly in table order. An entry with cmd=0 is still issued and occupies its slot.
- Asynchronous reset mid-sequence immediately forces reset values, including the idle bus. No CLEAR is issued.
- The arg field is passed through bit-exact, with no sign or width conversion.

Test Plan:
- Reset: hold rst_n=0 mid-WAIT → busy=0, net_addr=7 and net_cmd=0 immediately; after release, a start runs a full clean sequence.
- XOR config: load the 16-entry XOR table (e.g. entry0={1,1,7}, entry15={7,7,2}), start with N=16 and in1=1, in2=0 → 16 ISSUE/GAP pairs in order, CLEAR in cycle 33, done in cycle 69, result=1, spike_seen=1.
- Same table with in1=in2=1 → result=0; result_time equals net_out_time at the last window cycle.
- N=0 → CLEAR in cycle 1, done in cycle 2+WAIT_CYCLES, no ISSUE cycles.
- num_entries=20 → clamped to 16 entries. tbl_we during busy → entry unchanged on readback run.
- Start pulses during busy and in the done cycle → ignored (one done per sequence). Start in the next cycle → accepted.
